// File: rtl/keypad_pkg.sv
// Shared types and key map for the 4x3 microwave keypad scanner.
// Key codes, frame classes, debounce FSM states and the row/col to code lookup.
package keypad_pkg;

  localparam logic [3:0] KEY_0      = 4'h0;
  localparam logic [3:0] KEY_1      = 4'h1;
  localparam logic [3:0] KEY_2      = 4'h2;
  localparam logic [3:0] KEY_3      = 4'h3;
  localparam logic [3:0] KEY_4      = 4'h4;
  localparam logic [3:0] KEY_5      = 4'h5;
  localparam logic [3:0] KEY_6      = 4'h6;
  localparam logic [3:0] KEY_7      = 4'h7;
  localparam logic [3:0] KEY_8      = 4'h8;
  localparam logic [3:0] KEY_9      = 4'h9;
  localparam logic [3:0] KEY_CANCEL = 4'hA;
  localparam logic [3:0] KEY_START  = 4'hB;

  typedef enum logic [1:0] {NONE, SINGLE, MULTI} frame_class_t;

  typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESSED, RELEASE} key_state_t;

  function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    case ({row, col})
      4'b00_00: code = KEY_1;
      4'b00_01: code = KEY_2;
      4'b00_10: code = KEY_3;
      4'b01_00: code = KEY_4;
      4'b01_01: code = KEY_5;
      4'b01_10: code = KEY_6;
      4'b10_00: code = KEY_7;
      4'b10_01: code = KEY_8;
      4'b10_10: code = KEY_9;
      4'b11_00: code = KEY_CANCEL;
      4'b11_01: code = KEY_0;
      4'b11_10: code = KEY_START;
      default:  code = KEY_0;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/keypad_row_driver.sv
// Row scan timing: holds each row low for SCAN_DIV cycles and flags the
// column sample point (last slot cycle) and the end of a full frame.
module keypad_row_driver #(
  parameter int ROWS     = 4,
  parameter int SCAN_DIV = 1000
) (
  input  logic                    clock,
  input  logic                    reset_n,
  output logic [ROWS-1:0]         row_n,
  output logic [$clog2(ROWS)-1:0] row_idx,
  output logic                    sample_strobe,
  output logic                    frame_end
);

  localparam int                SLOT_W    = $clog2(SCAN_DIV);
  localparam int                ROW_W     = $clog2(ROWS);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(ROWS - 1);

  logic              running;
  logic [SLOT_W-1:0] slot_cnt;

  // running keeps all rows released while in reset; row 0 goes low on the
  // first clock after reset_n rises.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      running  <= 1'b0;
      slot_cnt <= '0;
      row_idx  <= '0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples the
      // pre-edge values; blocking ones would make order-dependent logic.
      running <= 1'b1;
      if (running) begin
        if (slot_cnt == SLOT_LAST) begin
          slot_cnt <= '0;
          row_idx  <= (row_idx == ROW_LAST) ? '0 : row_idx + ROW_W'(1);
        end else begin
          slot_cnt <= slot_cnt + SLOT_W'(1);
        end
      end
    end
  end

  assign sample_strobe = running && (slot_cnt == SLOT_LAST);
  assign frame_end     = sample_strobe && (row_idx == ROW_LAST);

  always_comb begin
    row_n = '1;
    if (running) row_n[row_idx] = 1'b0;
  end

endmodule

// File: rtl/keypad_scanner.sv
// Scanned 4x3 keypad front end: synchronizes columns, classifies each frame
// and debounces presses/releases over whole frames into one key event.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int ROWS           = 4,
  parameter int COLS           = 3,
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic [COLS-1:0] col_n,
  output logic [ROWS-1:0] row_n,
  output logic [3:0]      key_code,
  output logic            key_valid,
  output logic            key_held
);

  localparam int               ROW_W   = $clog2(ROWS);
  localparam int               CNT_W   = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_SCANS);

  logic [ROW_W-1:0] row_idx;
  logic             sample_strobe;
  logic             frame_end;

  keypad_row_driver #(
    .ROWS     (ROWS),
    .SCAN_DIV (SCAN_DIV)
  ) u_row_driver (
    .clock         (clock),
    .reset_n       (reset_n),
    .row_n         (row_n),
    .row_idx       (row_idx),
    .sample_strobe (sample_strobe),
    .frame_end     (frame_end)
  );

  // Idle columns are pulled up, so the synchronizer resets to all ones.
  logic [COLS-1:0] col_meta, col_sync;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      col_meta <= '1;
      col_sync <= '1;
    end else begin
      col_meta <= col_n;
      col_sync <= col_meta;
    end
  end

  // Hit counts saturate at 2: beyond that only "more than one" matters.
  logic [1:0]   row_hits, acc_hits, frame_hits;
  logic [3:0]   row_code, acc_code, frame_code;
  logic [2:0]   total_hits;
  frame_class_t frame_class;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first;
    // a path that leaves one unassigned would infer a latch.
    row_hits = 2'd0;
    row_code = KEY_0;
    for (int c = COLS - 1; c >= 0; c--) begin
      if (!col_sync[c]) begin
        if (row_hits != 2'd2) row_hits = row_hits + 2'd1;
        row_code = key_map(2'(row_idx), 2'(c));
      end
    end

    total_hits = {1'b0, acc_hits} + {1'b0, row_hits};
    frame_hits = (total_hits >= 3'd2) ? 2'd2 : total_hits[1:0];
    frame_code = (acc_hits == 2'd0) ? row_code : acc_code;
    case (frame_hits)
      2'd0:    frame_class = NONE;
      2'd1:    frame_class = SINGLE;
      default: frame_class = MULTI;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      acc_hits <= 2'd0;
      acc_code <= KEY_0;
    end else if (frame_end) begin
      acc_hits <= 2'd0;
      acc_code <= KEY_0;
    end else if (sample_strobe) begin
      acc_hits <= frame_hits;
      acc_code <= frame_code;
    end
  end

  key_state_t       state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d, cnt_inc;
  logic [3:0]       cand, cand_d, code_d;
  logic             valid_d, held_d;

  assign cnt_inc = cnt + CNT_W'(1);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      cand      <= KEY_0;
      key_code  <= KEY_0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      cand      <= cand_d;
      key_code  <= code_d;
      key_valid <= valid_d;
      key_held  <= held_d;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    cand_d  = cand;
    code_d  = key_code;
    valid_d = 1'b0;
    held_d  = key_held;

    if (frame_end) begin
      case (state)
        IDLE: begin
          if (frame_class == SINGLE) begin
            cand_d = frame_code;
            if (DEBOUNCE_SCANS == 1) begin
              code_d  = frame_code;
              valid_d = 1'b1;
              held_d  = 1'b1;
              cnt_d   = '0;
              state_d = PRESSED;
            end else begin
              cnt_d   = CNT_ONE;
              state_d = DEBOUNCE;
            end
          end
        end
        DEBOUNCE: begin
          if (frame_class == SINGLE && frame_code == cand) begin
            if (cnt_inc == CNT_MAX) begin
              code_d  = cand;
              valid_d = 1'b1;
              held_d  = 1'b1;
              cnt_d   = '0;
              state_d = PRESSED;
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            cnt_d   = '0;
            state_d = IDLE;
          end
        end
        PRESSED: begin
          // Other keys while held are ignored: no rollover, no second event.
          if (frame_class == NONE) begin
            if (DEBOUNCE_SCANS == 1) begin
              held_d  = 1'b0;
              cnt_d   = '0;
              state_d = IDLE;
            end else begin
              cnt_d   = CNT_ONE;
              state_d = RELEASE;
            end
          end
        end
        RELEASE: begin
          if (frame_class == NONE) begin
            if (cnt_inc == CNT_MAX) begin
              held_d  = 1'b0;
              cnt_d   = '0;
              state_d = IDLE;
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            cnt_d   = '0;
            state_d = PRESSED;
          end
        end
        default: begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a keypad matrix model drives col_n from row_n,
// expected key events go through a queue checked on every key_valid pulse.
module tb_keypad_scanner;

  localparam int FRAME = 16;

  logic       clock;
  logic       reset_n;
  logic [2:0] col_n;
  logic [3:0] row_n;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  logic [11:0] keys;
  int          cyc;
  int          pulse_cyc;
  int          n_checks;
  int          n_fail;
  logic [3:0]  exp_q[$];

  keypad_scanner #(
    .ROWS           (4),
    .COLS           (3),
    .SCAN_DIV       (4),
    .DEBOUNCE_SCANS (4)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .col_n     (col_n),
    .row_n     (row_n),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // A pressed key shorts its column to its row while that row is driven low.
  always_comb begin
    col_n = '1;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 3; c++)
        if (keys[r*3 + c] && !row_n[r]) col_n[c] = 1'b0;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clock);
      #1;
    end
  endtask

  task automatic set_key(input int r, input int c, input bit v);
    keys[r*3 + c] = v;
  endtask

  // Returns at the first cycle of the next frame (row 0 just driven low).
  task automatic frame_start();
    logic [3:0] prev;
    bit found;
    found = 1'b0;
    prev  = row_n;
    for (int i = 0; i < 3*FRAME && !found; i++) begin
      @(negedge clock);
      #1;
      if (row_n == 4'b1110 && prev != 4'b1110) found = 1'b1;
      prev = row_n;
    end
    check("frame_sync", 32'(found), 32'd1);
  endtask

  // Scoreboard: every key_valid pulse must match the oldest expected code.
  initial begin
    forever begin
      @(negedge clock);
      if (reset_n && key_valid) begin
        pulse_cyc = cyc;
        if (exp_q.size() == 0) check("unexpected_valid", 32'(key_valid), 32'd0);
        else                   check("key_code", 32'(key_code), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  t0;
    logic [3:0] exp_row;
    bit  held_ok;

    cyc       = 0;
    pulse_cyc = 0;
    n_checks  = 0;
    n_fail    = 0;
    keys      = '0;
    reset_n   = 1'b0;

    // 1. Reset values and row scan order.
    tick(5);
    check("rst_row_n", 32'(row_n), 32'hF);
    check("rst_key_code", 32'(key_code), 32'h0);
    check("rst_key_valid", 32'(key_valid), 32'h0);
    check("rst_key_held", 32'(key_held), 32'h0);
    reset_n = 1'b1;
    tick(1);
    for (int i = 0; i < FRAME; i++) begin
      exp_row = 4'hF;
      exp_row[i/4] = 1'b0;
      check("scan_row_n", 32'(row_n), 32'(exp_row));
      tick(1);
    end

    // 2. Steady press of key 6, accepted at the 4th frame end, then release.
    frame_start();
    set_key(1, 2, 1'b1);
    t0 = cyc;
    exp_q.push_back(4'h6);
    tick(4*FRAME - 1);
    check("s2_no_early_pulse", 32'(exp_q.size()), 32'd1);
    check("s2_held_early", 32'(key_held), 32'd0);
    tick(1);
    check("s2_pulse_seen", 32'(exp_q.size()), 32'd0);
    check("s2_latency", 32'(pulse_cyc - t0), 32'(4*FRAME));
    check("s2_held", 32'(key_held), 32'd1);
    tick(3*FRAME);
    frame_start();
    set_key(1, 2, 1'b0);
    tick(4*FRAME - 1);
    check("s2_held_until_release", 32'(key_held), 32'd1);
    tick(1);
    check("s2_released", 32'(key_held), 32'd0);
    check("s2_code_kept", 32'(key_code), 32'h6);

    // 3. Bounce on START: 2 frames on, 1 off, then steady.
    frame_start();
    set_key(3, 2, 1'b1);
    tick(2*FRAME);
    set_key(3, 2, 1'b0);
    tick(FRAME);
    set_key(3, 2, 1'b1);
    t0 = cyc;
    exp_q.push_back(4'hB);
    tick(4*FRAME - 1);
    check("s3_no_early_pulse", 32'(exp_q.size()), 32'd1);
    tick(1);
    check("s3_pulse_seen", 32'(exp_q.size()), 32'd0);
    check("s3_latency", 32'(pulse_cyc - t0), 32'(4*FRAME));
    set_key(3, 2, 1'b0);
    tick(6*FRAME);
    check("s3_released", 32'(key_held), 32'd0);

    // 4. Ghost: two keys together give nothing; dropping one accepts the other.
    frame_start();
    set_key(0, 0, 1'b1);
    set_key(2, 1, 1'b1);
    tick(6*FRAME);
    check("s4_multi_not_held", 32'(key_held), 32'd0);
    check("s4_multi_code_kept", 32'(key_code), 32'hB);
    frame_start();
    set_key(2, 1, 1'b0);
    t0 = cyc;
    exp_q.push_back(4'h1);
    tick(4*FRAME - 1);
    check("s4_no_early_pulse", 32'(exp_q.size()), 32'd1);
    tick(1);
    check("s4_pulse_seen", 32'(exp_q.size()), 32'd0);
    check("s4_latency", 32'(pulse_cyc - t0), 32'(4*FRAME));
    set_key(0, 0, 1'b0);
    tick(6*FRAME);
    check("s4_released", 32'(key_held), 32'd0);

    // 5. Release glitch shorter than the debounce window on key 0.
    frame_start();
    set_key(3, 1, 1'b1);
    exp_q.push_back(4'h0);
    tick(4*FRAME);
    check("s5_pulse_seen", 32'(exp_q.size()), 32'd0);
    check("s5_held", 32'(key_held), 32'd1);
    frame_start();
    set_key(3, 1, 1'b0);
    held_ok = 1'b1;
    for (int i = 0; i < 2*FRAME; i++) begin
      tick(1);
      held_ok &= key_held;
    end
    set_key(3, 1, 1'b1);
    for (int i = 0; i < 3*FRAME; i++) begin
      tick(1);
      held_ok &= key_held;
    end
    check("s5_held_through_glitch", 32'(held_ok), 32'd1);
    check("s5_code", 32'(key_code), 32'h0);
    set_key(3, 1, 1'b0);
    tick(6*FRAME);
    check("s5_released", 32'(key_held), 32'd0);

    // 6. Reset in the middle of debouncing key 4 after 3 good frames.
    frame_start();
    set_key(1, 0, 1'b1);
    tick(3*FRAME);
    reset_n = 1'b0;
    #1;
    check("s6_rst_row_n", 32'(row_n), 32'hF);
    check("s6_rst_key_code", 32'(key_code), 32'h0);
    check("s6_rst_key_valid", 32'(key_valid), 32'h0);
    check("s6_rst_key_held", 32'(key_held), 32'h0);
    tick(3);
    reset_n = 1'b1;
    tick(1);
    t0 = cyc;
    exp_q.push_back(4'h4);
    tick(4*FRAME - 1);
    check("s6_no_early_pulse", 32'(exp_q.size()), 32'd1);
    tick(1);
    check("s6_pulse_seen", 32'(exp_q.size()), 32'd0);
    check("s6_latency", 32'(pulse_cyc - t0), 32'(4*FRAME));
    set_key(1, 0, 1'b0);
    tick(6*FRAME);
    check("s6_released", 32'(key_held), 32'd0);
    check("s6_code_kept", 32'(key_code), 32'h4);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Drives the row lines of the microwave's 4x3 matrix keypad and reads its column lines back.
- Debounces the result over whole scan frames and emits one clean key event per press, with a 4-bit key code.
- Sits between the physical keypad pins and the microwave control FSM. It replaces per-button level cleaning with a scanned, code-producing front end.

Parameters:
- ROWS, 4, number of row lines driven (fixed keypad geometry; other values unsupported)
- COLS, 3, number of column lines read
- SCAN_DIV, 1000, clock cycles each row is held active (settle time); must be >= 2
- DEBOUNCE_SCANS, 4, consecutive identical full frames required to accept a press or a release; must be >= 1

Ports:
- clock  in  1  system clock; all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- col_n  in  COLS  keypad columns, active-low, externally pulled up, asynchronous to clock
- row_n  out  ROWS  row drive, active-low, at most one bit low
- key_code  out  4  code of the last accepted key
- key_valid  out  1  one-cycle pulse when a press is accepted
- key_held  out  1  high from acceptance until the release is debounced

Behaviour:
- Reset values (asynchronous on reset_n low):
  - row_n = all ones, key_code = 0, key_valid = 0, key_held = 0.
  - Row index = 0, slot counter = 0, FSM = IDLE, debounce counter = 0, candidate = 0.
- Reset deasserted mid-press: the FSM restarts from IDLE. No spurious key_valid is produced before DEBOUNCE_SCANS clean frames.
- Synchronizer: col_n passes through a 2-flop synchronizer. All decisions use the synchronized value.
- Row scan:
  - First cycle after reset release: row_n drives row 0 low.
  - Each row stays low for SCAN_DIV cycles.
  - Columns are sampled on the last cycle of the slot, when the slot counter = SCAN_DIV-1.
  - The row index then advances; ROWS-1 wraps to 0.
  - One frame = ROWS*SCAN_DIV cycles.
- Frame classification, at the end of the row ROWS-1 slot:
  - NONE: no column low in any row.
  - SINGLE(code): exactly one (row,col) low.
  - MULTI: two or more keys low; treated as no valid single key.
- Key map, code by row/col:
  - r0: 1, 2, 3
  - r1: 4, 5, 6
  - r2: 7, 8, 9
  - r3: CANCEL = 4'hA, 0 = 4'h0, START = 4'hB
- FSM, evaluated once per frame end:
  - IDLE:
    - SINGLE(k) -> candidate = k, cnt = 1, DEBOUNCE.
    - NONE or MULTI -> stay in IDLE.
    - If DEBOUNCE_SCANS = 1, accept immediately, using the DEBOUNCE acceptance rule.
  - DEBOUNCE:
    - SINGLE(candidate) -> cnt++.
    - When cnt reaches DEBOUNCE_SCANS: key_code = candidate, key_valid pulses in the same cycle, key_held = 1 the same cycle, go to PRESSED.
    - Any other class -> IDLE, cnt = 0, no output change.
  - PRESSED:
    - NONE -> cnt = 1, RELEASE.
    - SINGLE (same or other key) or MULTI -> stay in PRESSED. There is no rollover and no second event.
  - RELEASE:
    - NONE -> cnt++.
    - When cnt reaches DEBOUNCE_SCANS: key_held = 0, go to IDLE.
    - Any key -> PRESSED, with no new key_valid.
- key_code holds its value until the next acceptance. It is never cleared by release.
- key_valid is high for exactly one cycle per accepted press.
- Latency: a key pressed before a frame start and held steady is accepted at the end of frame DEBOUNCE_SCANS, plus the 2-cycle synchronizer skew.
- Counter widths:
  - slot counter: clog2(SCAN_DIV)
  - debounce counter: clog2(DEBOUNCE_SCANS+1)
  - Neither counter may wrap.

Decomposition:
- Package keypad_pkg holds:
  - key code constants KEY_0..KEY_9, KEY_CANCEL = 4'hA, KEY_START = 4'hB
  - the frame class enum {NONE, SINGLE, MULTI}
  - the FSM state enum {IDLE, DEBOUNCE, PRESSED, RELEASE}
  - the row/col to code mapping function
- Sub-module keypad_row_driver provides the slot counter, row index, row_n one-cold decode, and sample_strobe / frame_end strobes.
- Classification and the FSM stay in keypad_scanner.

Test Plan:
All scenarios use SCAN_DIV=4, DEBOUNCE_SCANS=4 (frame = 16 cycles) and a bench keypad model that pulls col_n[c] low while row_n[r] is low.
1. Reset: hold reset_n=0 for 5 cycles -> row_n=4'b1111, key_code=0, key_valid=0, key_held=0. After release, row_n cycles 1110, 1101, 1011, 0111, each for 4 cycles.
2. Press key (r1,c2) steadily -> exactly one key_valid pulse with key_code=4'h6 at the 4th frame end. key_held=1 until 4 NONE frames after release.
3. Bounce: (r3,c2) present for 2 frames, absent 1 frame, then steady -> no pulse until 4 consecutive frames. Then key_code=4'hB with one pulse.
4. Ghost: (r0,c0) and (r2,c1) pressed together -> no key_valid and key_held=0. Release r2,c1 -> after 4 frames, key_code=4'h1 with one pulse.
5. Release glitch: while (r3,c1) is held, drop the key for 2 frames and then restore -> key_held stays 1, no second pulse, key_code=4'h0.
6. Reset mid-DEBOUNCE, after 3 good frames -> outputs return to reset values. Requires 4 fresh frames before key_valid.
